// File: rtl/pmod_stand_spi_solo_pkg.sv
// Shared types and constants for the PMOD CLS SPI responder:
// display line type, ASCII codes used by the parser, parser states.
package pmod_stand_spi_solo_pkg;

   // One 16-character display line; element 0 is column 0.
   typedef logic [15:0][7:0] t_pmod_cls_ascii_line_16;

   localparam logic [7:0] c_ascii_esc      = 8'h1B;
   localparam logic [7:0] c_ascii_lbracket = 8'h5B;
   localparam logic [7:0] c_ascii_semi     = 8'h3B;
   localparam logic [7:0] c_ascii_j        = 8'h6A;
   localparam logic [7:0] c_ascii_H        = 8'h48;
   localparam logic [7:0] c_ascii_space    = 8'h20;

   typedef enum logic [2:0] {
      ST_TEXT,
      ST_ESC,
      ST_BRACKET,
      ST_PARAM0,
      ST_PARAM1
   } t_cls_parse_state;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= 8'h30) && (b <= 8'h39);
   endfunction

   // Decimal accumulate p*10 + digit, saturating at 255 so long digit
   // strings cannot wrap into a small cursor value.
   function automatic logic [7:0] dec_acc(input logic [7:0] p, input logic [7:0] b);
      logic [11:0] t;
      t = 12'(p) * 12'd10 + 12'(b - 8'h30);
      return (t > 12'd255) ? 8'hFF : t[7:0];
   endfunction

endpackage

// File: rtl/pmod_cls_spi_byte_rx.sv
// SPI mode 0 receive front end: synchronizes the bus pins into the clock
// domain, shifts COPI MSB-first on SCK rising edges while CSN is low, and
// flags frames that end on a partial byte.
module pmod_cls_spi_byte_rx (
   input  logic       clk,
   input  logic       rst,
   input  logic       sck,
   input  logic       csn,
   input  logic       copi,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_error
);

   logic [1:0] sck_s;
   logic [1:0] csn_s;
   logic [1:0] copi_s;
   logic       sck_d;
   logic       csn_d;
   logic [2:0] cnt;
   logic [6:0] shreg;
   logic       sck_rise;
   logic       csn_rise;

   assign sck_rise = sck_s[1] & ~sck_d;
   assign csn_rise = csn_s[1] & ~csn_d;

   // Synchronizers, edge detectors and the bit shifter. CSN idles high so
   // its synchronizer resets to 1 and a reset never looks like a CSN rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_s       <= 2'b00;
         csn_s       <= 2'b11;
         copi_s      <= 2'b00;
         sck_d       <= 1'b0;
         csn_d       <= 1'b1;
         cnt         <= 3'd0;
         shreg       <= 7'd0;
         byte_valid  <= 1'b0;
         byte_data   <= 8'd0;
         frame_error <= 1'b0;
      end else begin
         sck_s       <= {sck_s[0], sck};
         csn_s       <= {csn_s[0], csn};
         copi_s      <= {copi_s[0], copi};
         sck_d       <= sck_s[1];
         csn_d       <= csn_s[1];
         byte_valid  <= 1'b0;
         frame_error <= 1'b0;
         if (csn_rise) begin
            // End of frame: a partial byte is dropped and reported.
            if (cnt != 3'd0) frame_error <= 1'b1;
            cnt <= 3'd0;
         end else if (!csn_s[1] && sck_rise) begin
            if (cnt == 3'd7) begin
               byte_valid <= 1'b1;
               byte_data  <= {shreg, copi_s[1]};
               cnt        <= 3'd0;
            end else begin
               shreg <= {shreg[5:0], copi_s[1]};
               cnt   <= cnt + 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/pmod_cls_spi_responder.sv
// Emulates the PMOD CLS character LCD as an SPI target: receives bytes,
// interprets text and the ESC[j / ESC[r;cH escape sequences, and holds the
// two 16-character line buffers.
module pmod_cls_spi_responder
   import pmod_stand_spi_solo_pkg::*;
#(
   parameter int parm_cols = 16,
   parameter int parm_rows = 2
) (
   input  logic                    i_clk_20mhz,
   input  logic                    i_rst_20mhz,
   input  logic                    ei_sck,
   input  logic                    ei_csn,
   input  logic                    ei_copi,
   output logic                    eo_cipo_o,
   output logic                    eo_cipo_t,
   output logic                    o_byte_valid,
   output logic [7:0]              o_byte_data,
   output logic                    o_frame_error,
   output logic                    o_display_updated,
   output t_pmod_cls_ascii_line_16 o_line1,
   output t_pmod_cls_ascii_line_16 o_line2
);

   localparam logic [4:0] c_col_end  = 5'(parm_cols);
   localparam logic [7:0] c_col_max  = 8'(parm_cols - 1);
   localparam logic [7:0] c_row_max  = 8'(parm_rows - 1);
   localparam logic       c_last_row = 1'(parm_rows - 1);
   localparam t_pmod_cls_ascii_line_16 c_blank = {16{c_ascii_space}};

   t_cls_parse_state state;
   logic [7:0]       p0;
   logic [7:0]       p1;
   logic             row;
   logic [4:0]       col;      // reaches parm_cols when the line is full
   logic             changed;
   logic [7:0]       b;

   // The display never drives CIPO.
   assign eo_cipo_o = 1'b0;
   assign eo_cipo_t = 1'b1;
   assign b         = o_byte_data;

   pmod_cls_spi_byte_rx u_rx (
      .clk         (i_clk_20mhz),
      .rst         (i_rst_20mhz),
      .sck         (ei_sck),
      .csn         (ei_csn),
      .copi        (ei_copi),
      .byte_valid  (o_byte_valid),
      .byte_data   (o_byte_data),
      .frame_error (o_frame_error)
   );

   // Parser and line buffers; advances only on received bytes, so escape
   // sequences may span CSN frames. The update strobe trails the buffer
   // write by one cycle.
   always_ff @(posedge i_clk_20mhz) begin
      if (i_rst_20mhz) begin
         state             <= ST_TEXT;
         p0                <= 8'd0;
         p1                <= 8'd0;
         row               <= 1'b0;
         col               <= 5'd0;
         o_line1           <= c_blank;
         o_line2           <= c_blank;
         changed           <= 1'b0;
         o_display_updated <= 1'b0;
      end else begin
         changed           <= 1'b0;
         o_display_updated <= changed;
         if (o_byte_valid) begin
            case (state)
               ST_TEXT: begin
                  if (b == c_ascii_esc) begin
                     state <= ST_ESC;
                  end else if (b >= 8'h20 && b <= 8'h7E && col < c_col_end) begin
                     if (row) o_line2[col[3:0]] <= b;
                     else     o_line1[col[3:0]] <= b;
                     col     <= col + 5'd1;
                     changed <= 1'b1;
                  end
               end
               ST_ESC: begin
                  if (b == c_ascii_lbracket) begin
                     state <= ST_BRACKET;
                     p0    <= 8'd0;
                     p1    <= 8'd0;
                  end else begin
                     state <= ST_TEXT;
                  end
               end
               ST_BRACKET, ST_PARAM0, ST_PARAM1: begin
                  state <= ST_TEXT;
                  if (is_digit(b)) begin
                     if (state == ST_PARAM1) begin
                        p1    <= dec_acc(p1, b);
                        state <= ST_PARAM1;
                     end else begin
                        p0    <= dec_acc(p0, b);
                        state <= ST_PARAM0;
                     end
                  end else if (b == c_ascii_semi && state != ST_PARAM1) begin
                     state <= ST_PARAM1;
                  end else if (b == c_ascii_j) begin
                     o_line1 <= c_blank;
                     o_line2 <= c_blank;
                     row     <= 1'b0;
                     col     <= 5'd0;
                     changed <= 1'b1;
                  end else if (b == c_ascii_H && state != ST_BRACKET) begin
                     row <= (p0 >= c_row_max) ? c_last_row : p0[0];
                     col <= (p1 > c_col_max) ? 5'(c_col_max) : 5'(p1);
                  end
               end
               default: state <= ST_TEXT;
            endcase
         end
      end
   end

endmodule

// File: doc/pmod_cls_spi_responder.md
PMOD_CLS_SPI_RESPONDER -- requirements
Module: pmod_cls_spi_responder

Interface
REQ-001 SHALL have parameter parm_cols, default 16: characters per display line, fixed at 16.
REQ-002 SHALL have parameter parm_rows, default 2: number of display lines, fixed at 2.
REQ-003 SHALL have port i_clk_20mhz, input, 1 bit: the single clock, 20 MHz, at least 32x the SPI SCK frequency.
REQ-004 SHALL have port i_rst_20mhz, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports ei_sck, ei_csn, ei_copi, inputs, 1 bit each: SPI mode 0 bus from the controller.
REQ-006 SHALL have ports eo_cipo_o and eo_cipo_t, outputs, 1 bit each: constant 0 and 1 (CIPO tri-stated; the CLS does not talk back).
REQ-007 SHALL have port o_byte_valid, output, 1 bit: one-cycle strobe, one byte received.
REQ-008 SHALL have port o_byte_data, output, 8 bits: last received byte, valid with o_byte_valid.
REQ-009 SHALL have port o_frame_error, output, 1 bit: one-cycle strobe when CSN deasserts with 1-7 bits pending.
REQ-010 SHALL have port o_display_updated, output, 1 bit: one-cycle strobe after any change to the line buffers.
REQ-011 SHALL have ports o_line1 and o_line2, outputs, t_pmod_cls_ascii_line_16 each: display contents; element 0 is column 0.

Function
REQ-012 SHALL pass ei_sck, ei_csn and ei_copi through two-flop synchronizers, then detect SCK rising edges on the synchronized signal.
REQ-013 SHALL, while synchronized CSN is low, shift synchronized COPI MSB-first on each detected SCK rising edge.
REQ-014 SHALL assert o_byte_valid one cycle after the 8th edge and clear the bit counter; worst-case pin-to-strobe latency is 4 clocks.
REQ-015 SHALL, on synchronized CSN rising with a nonzero bit count, discard the partial byte, pulse o_frame_error and clear the counter.
REQ-016 SHALL ignore SCK edges while CSN is high; a counter at 0 on CSN rise SHALL raise no error.
REQ-017 SHALL run a parser FSM, advancing on o_byte_valid only, with states ST_TEXT, ST_ESC, ST_BRACKET, ST_PARAM0, ST_PARAM1.
REQ-018 SHALL, in ST_TEXT: byte 0x1B goes to ST_ESC; bytes 0x20-0x7E are written at (row, col), then col increments; other bytes are ignored.
REQ-019 SHALL, when col = 16, discard further text bytes; there is no wrap to the next line.
REQ-020 SHALL, in ST_ESC: 0x5B ('[') goes to ST_BRACKET, clearing p0 and p1; any other byte returns to ST_TEXT and is discarded.
REQ-021 SHALL, in ST_BRACKET/ST_PARAM0: a digit gives p0 = p0*10 + digit, saturating at 255; ';' goes to ST_PARAM1.
REQ-022 SHALL, in ST_PARAM1: a digit accumulates into p1 the same way.
REQ-023 SHALL treat 'j' (0x6A) in ST_BRACKET, ST_PARAM0 or ST_PARAM1 as clear display: fill both lines with 0x20, set row=0, col=0, return to ST_TEXT.
REQ-024 SHALL treat 'H' (0x48) in ST_PARAM0 or ST_PARAM1 as cursor set: row=min(p0,1), col=min(p1,15), return to ST_TEXT.
REQ-025 SHALL return to ST_TEXT without any buffer or cursor change on any other byte in the bracket or parameter states (e.g. ESC[0h, ESC[3e).
REQ-026 SHALL update buffers the cycle after o_byte_valid and pulse o_display_updated the following cycle.
REQ-027 SHALL NOT reset the parser state on CSN deassertion; escape sequences may span CSN frames.

Reset
REQ-028 SHALL, on i_rst_20mhz high at a clock edge: lines all 0x20, row=0, col=0, ST_TEXT, bit counter 0, synchronizers 1 for CSN and 0 for SCK/COPI, all strobes 0, o_byte_data 0.
REQ-029 SHALL abandon a byte or escape sequence in progress on reset, with no error strobe.

Structure
REQ-030 SHALL reuse t_pmod_cls_ascii_line_16 from pmod_stand_spi_solo_pkg.
REQ-031 SHALL add to pmod_stand_spi_solo_pkg the constants c_ascii_esc, c_ascii_lbracket, c_ascii_semi, c_ascii_j, c_ascii_H, c_ascii_space, and the parser state enum.
REQ-032 SHALL place synchronization and the byte shifter in one sub-module, pmod_cls_spi_byte_rx, with the parser and buffers in the top.

Verification
REQ-033 SHALL cover: after reset, send ESC[j then "Hi" at SCK 625 kHz -> o_line1[0:1]="Hi", rest 0x20, o_line2 all 0x20, 3 display-updated strobes.
REQ-034 SHALL cover: ESC[1;14H then "ABCD" -> o_line2[14]='A', o_line2[15]='B', 'C' and 'D' dropped.
REQ-035 SHALL cover: ESC[9;99H then "Z" -> o_line2[15]='Z' (clamped).
REQ-036 SHALL cover: CSN raised after 5 bits, then byte 0x41 -> one o_frame_error, next o_byte_data=0x41.
REQ-037 SHALL cover: ESC[0h then ESC X then "Q" -> no change from ESC[0h or ESC X, 'Q' written at the current cursor.
REQ-038 SHALL cover: reset asserted mid-sequence after ESC[1; then "K" -> 'K' at o_line1[0].
